sp_ram_bist: RTL and testbench

SP_RAM_BIST -- requirements
Module: sp_ram_bist

---
 rtl/sp_ram_bist_pkg.sv | 29 ++
 rtl/sp_ram_bist_if.sv | 28 ++
 rtl/bist_addr_cnt.sv | 43 ++++
 rtl/sp_ram_bist.sv | 190 +++++++++++++++++++
 tb/tb_sp_ram_bist.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_bist_pkg.sv
// Shared definitions for the single-port RAM march-test BIST: defaults,
// FSM state encoding and per-address phase cycle counts.
package sp_ram_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 8;

  // Cycles spent per address in each phase of a clean run
  localparam int unsigned W0_CYC_PER_ADDR     = 1;
  localparam int unsigned MARCH0_CYC_PER_ADDR = 2;
  localparam int unsigned MARCH1_CYC_PER_ADDR = 2;
  localparam int unsigned RUN_CYC_PER_ADDR    =
    W0_CYC_PER_ADDR + MARCH0_CYC_PER_ADDR + MARCH1_CYC_PER_ADDR;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_RD0  = 3'd2,
    ST_CW1  = 3'd3,
    ST_RD1  = 3'd4,
    ST_CK1  = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  function automatic int unsigned run_cycles(input int unsigned addr_w);
    return RUN_CYC_PER_ADDR << addr_w;
  endfunction

endpackage

// File: rtl/sp_ram_bist_if.sv
// RAM port between the BIST initiator (master) and the attached single-port RAM (slave).
interface sp_ram_bist_if
  import sp_ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_we,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    output mem_q
  );

endinterface

// File: rtl/bist_addr_cnt.sv
// Loadable up/down address counter with terminal-value flags for the march test.
module bist_addr_cnt #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] cnt,
  output logic              is_max,
  output logic              is_zero
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Load has priority; inc and dec are never requested together
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end else if (dec) begin
      cnt_d = cnt_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_max  = &cnt_q;
  assign is_zero = ~|cnt_q;

endmodule

// File: rtl/sp_ram_bist.sv
// Three-phase march BIST for a single-port RAM: write P ascending, read P /
// write ~P ascending, read ~P descending; reports pass or the first mismatch.
module sp_ram_bist
  import sp_ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  sp_ram_bist_if.master     mem
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_data_q, err_data_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;

  logic              cnt_load;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_is_max;
  logic              cnt_is_zero;
  logic              cw1_we_c;
  logic              match_p_c;
  logic              match_np_c;

  bist_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val ('0),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_max   (cnt_is_max),
    .is_zero  (cnt_is_zero)
  );

  assign match_p_c  = (mem.mem_q == pat_q);
  assign match_np_c = (mem.mem_q == ~pat_q);

  // Next-state, counter control and registered-output updates
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    data_d     = data_q;
    we_d       = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    cw1_we_c   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pat_d    = pattern;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          cnt_load = 1'b1;
          data_d   = pattern;
          we_d     = 1'b1;
          state_d  = ST_W0;
        end
      end
      ST_W0: begin
        if (cnt_is_max) begin
          cnt_load = 1'b1;
          state_d  = ST_RD0;
        end else begin
          cnt_inc = 1'b1;
          we_d    = 1'b1;
        end
      end
      ST_RD0: begin
        data_d  = ~pat_q;
        state_d = ST_CW1;
      end
      ST_CW1: begin
        if (match_p_c) begin
          cw1_we_c = 1'b1;
          if (cnt_is_max) begin
            state_d = ST_RD1;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_RD0;
          end
        end else begin
          err_addr_d = cnt;
          err_data_d = mem.mem_q;
          fail_d     = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_RD1: begin
        state_d = ST_CK1;
      end
      ST_CK1: begin
        if (!match_np_c) begin
          err_addr_d = cnt;
          err_data_d = mem.mem_q;
          fail_d     = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_is_zero) begin
          err_addr_d = '0;
          err_data_d = '0;
          pass_d     = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = ST_RD1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_addr = err_addr_q;
  assign err_data = err_data_q;

  // The CW1 write depends on this cycle's read data, so it cannot be registered
  assign mem.mem_addr = cnt;
  assign mem.mem_data = data_q;
  assign mem.mem_we   = we_q | cw1_we_c;

endmodule

// File: tb/tb_sp_ram_bist.sv
// Bench for sp_ram_bist: behavioural RAM with a stuck-at fault hook, and a
// march-algorithm model giving the expected per-cycle RAM traffic and result.
module tb_sp_ram_bist;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] pattern;
  logic          busy, done, pass, fail;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;

  sp_ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  sp_ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .err_addr (err_addr),
    .err_data (err_data),
    .mem      (ram_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Fault configuration: one bit of one address reads back stuck
  bit          fault_en  = 1'b0;
  int          fault_addr = 0;
  int          fault_bit  = 0;
  logic        fault_val  = 1'b0;

  function automatic logic [DW-1:0] flt(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  logic [DW-1:0] ram [DEPTH];

  always @(posedge clk) begin
    if (ram_if.mem_we) ram[ram_if.mem_addr] <= ram_if.mem_data;
    ram_if.mem_q <= flt(int'(ram_if.mem_addr), ram[ram_if.mem_addr]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: expected RAM traffic per busy cycle and final result
  exp_t          exp_q[$];
  int            exp_len, exp_wr;
  bit            exp_pass;
  logic [AW-1:0] exp_err_addr;
  logic [DW-1:0] exp_err_data;

  task automatic build_model(input logic [DW-1:0] p);
    exp_t          e;
    logic [DW-1:0] v;
    bit            bad;
    bad = 1'b0;
    exp_q.delete();
    exp_wr = 0;
    exp_err_addr = '0;
    exp_err_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      e.we = 1'b1; e.addr = AW'(a); e.data = p;
      exp_q.push_back(e); exp_wr++;
    end
    for (int a = 0; a < DEPTH; a++) begin
      e.we = 1'b0; e.addr = AW'(a); e.data = '0;
      exp_q.push_back(e);
      v = flt(a, p);
      if (v !== p) begin
        exp_q.push_back(e);
        bad = 1'b1; exp_err_addr = AW'(a); exp_err_data = v;
        break;
      end
      e.we = 1'b1; e.data = ~p;
      exp_q.push_back(e); exp_wr++;
    end
    if (!bad) begin
      for (int a = DEPTH - 1; a >= 0; a--) begin
        e.we = 1'b0; e.addr = AW'(a); e.data = '0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        v = flt(a, ~p);
        if (v !== ~p) begin
          bad = 1'b1; exp_err_addr = AW'(a); exp_err_data = v;
          break;
        end
      end
    end
    exp_pass = !bad;
    exp_len  = exp_q.size();
  endtask

  // Per-cycle compare of the RAM port and status while a run is in progress
  bit mon_on = 1'b0;
  int n_busy, n_wr;

  always @(negedge clk) begin
    if (mon_on && busy) begin
      exp_t e;
      n_busy++;
      if (ram_if.mem_we) n_wr++;
      if (exp_q.size() == 0) begin
        chk("busy_overrun", 32'(busy), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("mem_we", 32'(ram_if.mem_we), 32'(e.we));
        chk("mem_addr", 32'(ram_if.mem_addr), 32'(e.addr));
        if (e.we) chk("mem_data", 32'(ram_if.mem_data), 32'(e.data));
      end
      chk("flags_in_run", {29'd0, done, pass, fail}, 32'd0);
    end
  end

  task automatic run(input logic [DW-1:0] p, input int inj_cyc, input logic [DW-1:0] inj_pat);
    int cyc;
    build_model(p);
    n_busy = 0;
    n_wr   = 0;
    mon_on = 1'b1;
    @(negedge clk);
    start = 1'b1; pattern = p;
    @(negedge clk);
    start = 1'b0; pattern = DW'($urandom);
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc == inj_cyc) begin start = 1'b1; pattern = inj_pat; end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    mon_on = 1'b0;
    chk("run_timeout", 32'(done), 32'd1);
    chk("busy_cycles", 32'(n_busy), 32'(exp_len));
    chk("write_cycles", 32'(n_wr), 32'(exp_wr));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("pass", 32'(pass), 32'(exp_pass));
    chk("fail", 32'(fail), 32'(!exp_pass));
    chk("err_addr", 32'(err_addr), 32'(exp_err_addr));
    chk("err_data", 32'(err_data), 32'(exp_err_data));
    repeat (3) begin
      @(negedge clk);
      chk("idle_we", {30'd0, busy, ram_if.mem_we}, 32'd0);
    end
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input logic v);
    fault_en = en; fault_addr = a; fault_bit = b; fault_val = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    pattern = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_status", {25'd0, busy, done, pass, fail, ram_if.mem_we, 2'b00}, 32'd0);
    chk("reset_err", {16'd0, 2'b00, err_addr, err_data}, 32'd0);
    chk("reset_mem", {18'd0, ram_if.mem_addr, ram_if.mem_data}, 32'd0);

    // Release just after an edge so the very next edge sees the start
    @(posedge clk); #1 rst_n = 1'b1;

    // Fault-free, P=AA
    set_fault(1'b0, 0, 0, 1'b0);
    run(8'hAA, -1, 8'h00);
    chk("lit_clean_busy", 32'(n_busy), 32'd320);
    chk("lit_clean_wr", 32'(n_wr), 32'd128);
    chk("lit_clean_pass", {30'd0, pass, fail}, 32'b10);

    // Addr 5 bit0 stuck-at-1, P=AA
    set_fault(1'b1, 5, 0, 1'b1);
    run(8'hAA, -1, 8'h00);
    chk("lit_sa1_fail", 32'(fail), 32'd1);
    chk("lit_sa1_addr", 32'(err_addr), 32'd5);
    chk("lit_sa1_data", 32'(err_data), 32'hAB);
    chk("lit_sa1_busy", 32'(n_busy), 32'd76);

    // Addr 63 bit7 stuck-at-0, P=55: caught at the first CK1
    set_fault(1'b1, 63, 7, 1'b0);
    run(8'h55, -1, 8'h00);
    chk("lit_sa0_addr", 32'(err_addr), 32'd63);
    chk("lit_sa0_data", 32'(err_data), 32'h2A);
    chk("lit_sa0_busy", 32'(n_busy), 32'd194);

    // Start from DONE with P=00 after a failed run, fault removed
    set_fault(1'b0, 0, 0, 1'b0);
    run(8'h00, -1, 8'h00);
    chk("lit_p00_pass", 32'(pass), 32'd1);

    // Start pulsed mid-run is ignored
    run(8'hAA, 50, 8'h0F);
    chk("lit_inj_busy", 32'(n_busy), 32'd320);

    // Reset mid-run during a CW1 write cycle
    build_model(8'hAA);
    mon_on = 1'b1;
    @(negedge clk); start = 1'b1; pattern = 8'hAA;
    @(negedge clk); start = 1'b0;
    repeat (101) @(negedge clk);
    mon_on = 1'b0;
    chk("pre_rst_we", 32'(ram_if.mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_status", {25'd0, busy, done, pass, fail, ram_if.mem_we, 2'b00}, 32'd0);
    chk("rst_err", {16'd0, 2'b00, err_addr, err_data}, 32'd0);
    chk("rst_mem", {18'd0, ram_if.mem_addr, ram_if.mem_data}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", {29'd0, busy, done, ram_if.mem_we}, 32'd0);
    end
    run(8'hC3, -1, 8'h00);

    // Randomised patterns and faults
    for (int r = 0; r < 8; r++) begin
      set_fault(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, DW - 1)), 1'($urandom_range(0, 1)));
      run(DW'($urandom), (r % 3 == 0) ? int'($urandom_range(1, 150)) : -1, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
